// File: rtl/pwm_timebase.sv
// Prescaled PWM timebase with up, down and centre-aligned counting.
// Period, prescale and mode are shadowed and reload only at cycle boundaries.
module pwm_timebase #(
  parameter int WIDTH = 16,
  parameter int PS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] period,
  input  logic [PS_W-1:0]  prescale,
  output logic [WIDTH-1:0] count_val,
  output logic             dir,
  output logic             ovf,
  output logic             unf,
  output logic             upd
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_CENTRE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
  localparam logic [PS_W-1:0]  ONE_PS  = PS_W'(1);
  localparam logic [WIDTH:0]   ONE_W1  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [PS_W-1:0]  psc_cnt_reg, psc_cnt_next;
  logic             dir_reg, dir_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             upd_reg, upd_next;
  logic [WIDTH-1:0] per_sh_reg, per_sh_next;
  logic [PS_W-1:0]  psc_sh_reg, psc_sh_next;
  mode_t            mode_sh_reg, mode_sh_next;

  logic             tick;
  logic             load_sh;
  logic             upd_evt;
  logic [WIDTH:0]   count_inc;
  mode_t            mode_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      psc_cnt_reg <= '0;
      dir_reg     <= 1'b1;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
      upd_reg     <= 1'b0;
      per_sh_reg  <= '0;
      psc_sh_reg  <= '0;
      mode_sh_reg <= MODE_UP;
    end else begin
      count_reg   <= count_next;
      psc_cnt_reg <= psc_cnt_next;
      dir_reg     <= dir_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
      upd_reg     <= upd_next;
      per_sh_reg  <= per_sh_next;
      psc_sh_reg  <= psc_sh_next;
      mode_sh_reg <= mode_sh_next;
    end
  end

  always_comb begin
    count_next   = count_reg;
    psc_cnt_next = psc_cnt_reg;
    dir_next     = dir_reg;
    ovf_next     = 1'b0;
    unf_next     = 1'b0;
    upd_next     = 1'b0;
    per_sh_next  = per_sh_reg;
    psc_sh_next  = psc_sh_reg;
    mode_sh_next = mode_sh_reg;
    load_sh      = 1'b0;
    upd_evt      = 1'b0;
    mode_in      = mode_t'(mode);
    tick         = (psc_cnt_reg == psc_sh_reg);
    // One extra bit so the centre-mode top compare cannot wrap at all-ones.
    count_inc    = {1'b0, count_reg} + ONE_W1;

    if (count_reset) begin
      psc_cnt_next = '0;
      load_sh      = 1'b1;
      upd_next     = 1'b1;
      count_next   = (mode_in == MODE_DOWN) ? period : '0;
      dir_next     = (mode_in != MODE_DOWN);
    end else if (!en) begin
      load_sh = 1'b1;
    end else begin
      psc_cnt_next = tick ? '0 : psc_cnt_reg + ONE_PS;
      if (tick) begin
        unique case (mode_sh_reg)
          MODE_UP: begin
            dir_next = 1'b1;
            if (count_reg >= per_sh_reg) begin
              count_next = '0;
              ovf_next   = 1'b1;
              upd_evt    = 1'b1;
            end else begin
              count_next = count_reg + ONE_W;
            end
          end
          MODE_DOWN: begin
            dir_next = 1'b0;
            if (count_reg == '0) begin
              count_next = per_sh_reg;
              unf_next   = 1'b1;
              upd_evt    = 1'b1;
            end else begin
              count_next = count_reg - ONE_W;
            end
          end
          MODE_CENTRE: begin
            // A zero period collapses peak and valley into the same tick.
            if (per_sh_reg == '0) begin
              count_next = '0;
              dir_next   = 1'b1;
              ovf_next   = 1'b1;
              unf_next   = 1'b1;
              upd_evt    = 1'b1;
            end else if (dir_reg) begin
              if (count_inc >= {1'b0, per_sh_reg}) begin
                count_next = per_sh_reg;
                dir_next   = 1'b0;
                ovf_next   = 1'b1;
              end else begin
                count_next = count_inc[WIDTH-1:0];
              end
            end else begin
              if (count_reg <= ONE_W) begin
                count_next = '0;
                dir_next   = 1'b1;
                unf_next   = 1'b1;
                upd_evt    = 1'b1;
              end else begin
                count_next = count_reg - ONE_W;
              end
            end
          end
          default: begin
          end
        endcase
      end
      if (upd_evt) begin
        load_sh  = 1'b1;
        upd_next = 1'b1;
      end
    end

    if (load_sh) begin
      per_sh_next  = period;
      psc_sh_next  = prescale;
      mode_sh_next = mode_in;
    end
  end

  assign count_val = count_reg;
  assign dir       = dir_reg;
  assign ovf       = ovf_reg;
  assign unf       = unf_reg;
  assign upd       = upd_reg;

endmodule
